// File: rtl/ioctl_wr_pkg.sv
// Shared types for the ROM download writer.
//   wr_state_t : request FSM states
//   wr_entry_t : one captured download byte {addr, data}
//   port_sel_t : which SDRAM port an entry is routed to
package ioctl_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_GFX = 1'b1
  } port_sel_t;

endpackage

// File: rtl/ioctl_fifo.sv
// Small synchronous FIFO for captured download bytes.
// Ports:
//   clk_sys, reset_n     : clock, synchronous active-low reset
//   push, push_data      : write request and entry
//   pop, pop_data        : read request; pop_data shows the head entry
//   full, empty, count   : occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
module ioctl_fifo
  import ioctl_wr_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  wr_entry_t        push_data,
  input  logic             pop,
  output wr_entry_t        pop_data,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 1 << FIFO_AW;

  wr_entry_t          mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ioctl_sdram_writer.sv
// Turns the data_io byte download into toggle-handshake SDRAM writes on
// port1 (CPU ROM, below BG_BASE) and port2 (background/sprites, from BG_BASE),
// and generates rom_loaded plus a held core reset once the download drains.
// Ports:
//   clk_sys, reset_n            : clock, synchronous active-low reset
//   ioctl_*                     : download stream from data_io
//   port1_* / port2_*           : SDRAM write ports (req/ack are toggles)
//   rom_loaded, core_reset_n    : download complete / game core reset
//   busy, overflow              : activity and sticky dropped-byte flag
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting; pops FIFO head and loads the routed port outputs
// ISSUE    | toggles the selected port's req
// WAIT_ACK | waits for ack == req, then drops we
module ioctl_sdram_writer
  import ioctl_wr_pkg::*;
#(
  parameter logic [24:0] BG_BASE    = 25'hC000,
  parameter int          FIFO_AW    = 2,
  parameter logic [15:0] RESET_HOLD = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        core_reset_n,
  output logic        busy,
  output logic        overflow
);

  wr_state_t        state, next_state;
  port_sel_t        sel_q;
  wr_entry_t        in_entry, head;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_AW:0] fifo_count;
  logic             wr_prev, dl_prev, fell_seen;
  logic             wr_rise, dl_rise, dl_fall, push;
  logic             load_req, issue, done;
  logic             req_sel, ack_sel, head_gfx, loaded_now;
  logic [23:0]      bg_off;
  logic [15:0]      hold_cnt;

  assign wr_rise  = ioctl_wr & ~wr_prev;
  assign dl_rise  = ioctl_download & ~dl_prev;
  assign dl_fall  = ~ioctl_download & dl_prev;
  assign push     = wr_rise & ioctl_download & (ioctl_index == 8'd0);
  assign in_entry = '{addr: ioctl_addr, data: ioctl_dout};

  ioctl_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_sel  = (sel_q == PORT_GFX) ? port2_req : port1_req;
  assign ack_sel  = (sel_q == PORT_GFX) ? port2_ack : port1_ack;
  assign head_gfx = (head.addr >= BG_BASE);
  // Offset bit 13 picks the byte lane; the word address skips it.
  assign bg_off   = 24'(head.addr - BG_BASE);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    load_req   = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          load_req   = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue      = 1'b1;
        next_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_sel == req_sel) begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sel_q     <= PORT_CPU;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_we  <= 1'b0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_we  <= 1'b0;
      port2_d   <= '0;
    end else begin
      if (load_req) begin
        if (head_gfx) begin
          sel_q    <= PORT_GFX;
          port2_a  <= {bg_off[23:14], bg_off[12:0]};
          port2_ds <= {bg_off[13], ~bg_off[13]};
          port2_d  <= {head.data, head.data};
          port2_we <= 1'b1;
        end else begin
          sel_q    <= PORT_CPU;
          port1_a  <= head.addr[23:1];
          port1_ds <= {head.addr[0], ~head.addr[0]};
          port1_d  <= {head.data, head.data};
          port1_we <= 1'b1;
        end
      end
      if (issue) begin
        if (sel_q == PORT_GFX) port2_req <= ~port2_req;
        else                   port1_req <= ~port1_req;
      end
      if (done) begin
        if (sel_q == PORT_GFX) port2_we <= 1'b0;
        else                   port1_we <= 1'b0;
      end
    end
  end

  // Download counts as finished only once a falling edge was seen and
  // every queued byte has been acknowledged.
  assign loaded_now = ~ioctl_download & (fell_seen | dl_fall) & fifo_empty &
                      (state == ST_IDLE) & ~rom_loaded;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_prev      <= 1'b0;
      dl_prev      <= 1'b0;
      fell_seen    <= 1'b0;
      rom_loaded   <= 1'b0;
      core_reset_n <= 1'b0;
      overflow     <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      wr_prev <= ioctl_wr;
      dl_prev <= ioctl_download;
      if (dl_rise) begin
        rom_loaded   <= 1'b0;
        core_reset_n <= 1'b0;
        overflow     <= 1'b0;
        fell_seen    <= 1'b0;
      end else begin
        if (dl_fall) fell_seen <= 1'b1;
        if (loaded_now) begin
          rom_loaded <= 1'b1;
          fell_seen  <= 1'b0;
          hold_cnt   <= RESET_HOLD - 16'd1;
        end else if (rom_loaded && !core_reset_n) begin
          if (hold_cnt == 16'd0) core_reset_n <= 1'b1;
          else                   hold_cnt     <= hold_cnt - 16'd1;
        end
      end
      if (push && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  assign busy = (fifo_count != '0) | (state != ST_IDLE);

endmodule

// File: doc/ioctl_sdram_writer.md
# ioctl_sdram_writer

Converts the byte-wide ROM download stream from `data_io` into toggle-handshake write requests on the SDRAM controller's `port1` (CPU ROM region) and `port2` (background/sprite region), with a small FIFO that absorbs SDRAM latency. It also produces `rom_loaded` and a held core reset once the download has fully drained. It sits between `data_io` and `sdram` in the top level, replacing the ad-hoc download controller and the reset logic.

## Interface
- `BG_BASE`, 25'hC000, first download address routed to `port2`.
- `FIFO_AW`, 2, FIFO address width; depth is 2^FIFO_AW entries.
- `RESET_HOLD`, 16'd1024, clock cycles `core_reset_n` stays low after `rom_loaded` rises.

- `clk_sys`  in  1  system clock (48 MHz domain); single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `ioctl_download`  in  1  download active.
- `ioctl_index`  in  8  download index; only index 0 is written.
- `ioctl_wr`  in  1  byte strobe (level, rising edge is significant).
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `port1_req` / `port2_req`  out  1  request toggle.
- `port1_ack` / `port2_ack`  in  1  acknowledge toggle.
- `port1_a` / `port2_a`  out  23  word address.
- `port1_ds` / `port2_ds`  out  2  byte strobes {hi,lo}.
- `port1_we` / `port2_we`  out  1  write enable.
- `port1_d` / `port2_d`  out  16  write data.
- `rom_loaded`  out  1  download complete and drained.
- `core_reset_n`  out  1  active-low reset for the game core.
- `busy`  out  1  FIFO not empty or FSM not IDLE.
- `overflow`  out  1  sticky; a byte was dropped.

## Operation
- Capture: rising edge of `ioctl_wr` (registered previous value) while `ioctl_download` is high and `ioctl_index == 0` pushes {addr, dout}. Other indices are ignored.
- Push while full with no pop in the same cycle: the byte is dropped and `overflow` is set. Push while full with a pop in the same cycle is accepted.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head, select the port, load that port's a/ds/d, set its `we`, and go to ISSUE.
  - ISSUE: toggle the selected `portN_req`; go to WAIT_ACK.
  - WAIT_ACK: when `portN_ack == portN_req`, clear `we` and go to IDLE.
- Routing, with A = entry address:
  - A < BG_BASE → port1: `a` = A[23:1], `ds` = {A[0], ~A[0]}.
  - A ≥ BG_BASE → port2: O = A − BG_BASE (25-bit); `a` = {O[23:14], O[12:0]}; `ds` = {O[13], ~O[13]}.
  - Data is always {dout, dout}. The unselected port's outputs are unchanged.
- Download rising edge clears `rom_loaded` and `overflow`.
- `rom_loaded` sets on the first cycle where the download is low, a falling edge has been seen since the last set, the FIFO is empty, and the FSM is IDLE.
- `core_reset_n` is 0 while `rom_loaded` = 0. It is released after a counter counts RESET_HOLD cycles from the `rom_loaded` rise; a clear of `rom_loaded` re-asserts it immediately.
- `reset_n` low returns everything to reset values mid-transfer. Pending FIFO contents are discarded, and `req` returns to 0; the sdram side must be reset alongside.

## Timing
- Reset values: all `req`/`we`/`a`/`ds`/`d` = 0, `rom_loaded` = 0, `core_reset_n` = 0, `overflow` = 0, `busy` = 0.
- `ioctl_wr` rises at cycle n → entry is in the FIFO at n+1 → outputs are loaded at n+2 (IDLE) → `req` toggles at n+3, with address and data already stable one cycle before.
- Minimum 4 cycles per byte with immediate ack. `req` never toggles again before the matching ack.
- `rom_loaded` rises no earlier than the cycle after the last WAIT_ACK→IDLE.
- `core_reset_n` rises exactly RESET_HOLD cycles after `rom_loaded`.

## Structure
- Package `ioctl_wr_pkg`: FSM enum (IDLE, ISSUE, WAIT_ACK), entry struct {addr[24:0], data[7:0]}, port-select enum.
- Sub-module `ioctl_fifo`: synchronous FIFO with parameter FIFO_AW, providing push/pop/full/empty and count; first-word-fall-through not required.

## Test plan
- Write 0x0000=0x12, 0x0001=0x34 with ack after 3 cycles → port1 issues a=0, ds=10→… ; first ds=01, d=1212; second ds=10, d=3434; port2 idle.
- Write 0xC000=0xAA and 0xE000=0xBB → port2 a=0, ds=01 then a=0, ds=10; port1 untouched.
- Hold ack for 200 cycles while pushing 6 bytes → 4 accepted plus the one in flight, `overflow`=1, and exactly 5 requests observed.
- Download ends with 3 entries queued → `rom_loaded` rises only after the third ack; `core_reset_n` rises RESET_HOLD cycles later.
- Bytes with `ioctl_index`=1 → no requests, `busy` stays 0.
- `reset_n` low during WAIT_ACK → next cycle all outputs are at reset values; a new download proceeds normally.
